imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the core's combinational immediate generator. Decodes the RV32I/RV64I immediate in XLEN width, sign-extends by default, and reports the instruction format and CSR zimm.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so it can sit between fetch and decode/execute without losing throughput.
- Counts output back-pressure cycles.

---
 rtl/imm_pkg.sv | 42 ++++
 rtl/imm_decode.sv | 58 +++++
 rtl/imm_gen_pipe.sv | 137 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared opcode, immediate-format and skid-state encodings for the immediate generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imm_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'h03;
    localparam logic [6:0] OPC_OPIMM   = 7'h13;
    localparam logic [6:0] OPC_OPIMM32 = 7'h1B;
    localparam logic [6:0] OPC_JALR    = 7'h67;
    localparam logic [6:0] OPC_SYSTEM  = 7'h73;
    localparam logic [6:0] OPC_STORE   = 7'h23;
    localparam logic [6:0] OPC_BRANCH  = 7'h63;
    localparam logic [6:0] OPC_AUIPC   = 7'h17;
    localparam logic [6:0] OPC_LUI     = 7'h37;
    localparam logic [6:0] OPC_JAL     = 7'h6F;
    localparam logic [6:0] OPC_FENCE   = 7'h0F;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_CSR  = 3'd6,
        FMT_RSVD = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    // Width-independent part of a pipeline entry; imm and tag are parameterised separately.
    typedef struct packed {
        logic [31:0] inst;
        fmt_e        fmt;
        logic [4:0]  zimm;
    } meta_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decode: format, XLEN-wide immediate, CSR zimm.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output tracks inst directly.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SIGN_EXT = 1
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic [4:0]      zimm
);

    logic        fill;
    logic [63:0] imm64;
    logic        unused_funct3;

    // funct3 never contributes to an immediate
    assign unused_funct3 = ^inst[14:12];

    always_comb begin
        fill  = (SIGN_EXT != 0) ? inst[31] : 1'b0;
        fmt   = FMT_NONE;
        imm64 = '0;
        zimm  = '0;

        case (inst[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_FENCE: fmt = FMT_I;
            OPC_OPIMM32:                              fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
            OPC_SYSTEM:                               fmt = FMT_CSR;
            OPC_STORE:                                fmt = FMT_S;
            OPC_BRANCH:                               fmt = FMT_B;
            OPC_AUIPC, OPC_LUI:                       fmt = FMT_U;
            OPC_JAL:                                  fmt = FMT_J;
            default:                                  fmt = FMT_NONE;
        endcase

        // Assemble at 64 bits and truncate; at XLEN=32 the U fill drops out naturally.
        case (fmt)
            FMT_I:   imm64 = {{52{fill}}, inst[31:20]};
            FMT_S:   imm64 = {{52{fill}}, inst[31:25], inst[11:7]};
            FMT_B:   imm64 = {{51{fill}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm64 = {{32{fill}}, inst[31:12], 12'b0};
            FMT_J:   imm64 = {{43{fill}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_CSR: begin
                // CSR address is an unsigned index, never sign-extended
                imm64 = {52'b0, inst[31:20]};
                zimm  = inst[19:15];
            end
            default: imm64 = '0;
        endcase
    end

    assign imm = XLEN'(imm64);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode, then a 2-entry skid register stage with a stall counter.
// Latency: 1 cycle from accept to out_valid when empty; 1 result/cycle while out_ready=1.
// Backpressure: in_ready is registered (never combinational on out_ready); drops when both entries fill.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int SIGN_EXT = 1,
    parameter int TAG_W    = 32,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [4:0]       out_zimm,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [XLEN-1:0]  dec_imm;
    fmt_e             dec_fmt;
    logic [4:0]       dec_zimm;
    meta_t            in_meta;

    skid_state_e      state_q, state_d;
    logic             in_ready_q;
    meta_t            main_meta_q, skid_meta_q;
    logic [XLEN-1:0]  main_imm_q, skid_imm_q;
    logic [TAG_W-1:0] main_tag_q, skid_tag_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             acc, dq;
    logic             ld_main_in, ld_main_skid, ld_skid;

    imm_decode #(
        .XLEN     (XLEN),
        .SIGN_EXT (SIGN_EXT)
    ) u_imm_decode (
        .inst (in_inst),
        .imm  (dec_imm),
        .fmt  (dec_fmt),
        .zimm (dec_zimm)
    );

    assign in_meta = '{inst: in_inst, fmt: dec_fmt, zimm: dec_zimm};

    assign out_valid = (state_q != SKID_EMPTY);
    assign acc       = in_valid && in_ready_q;
    assign dq        = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (acc) begin
                    state_d    = SKID_ONE;
                    ld_main_in = 1'b1;
                end
            end
            SKID_ONE: begin
                if (acc && dq) begin
                    ld_main_in = 1'b1;
                end else if (acc) begin
                    state_d = SKID_FULL;
                    ld_skid = 1'b1;
                end else if (dq) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so acc cannot fire
                if (dq) begin
                    state_d      = SKID_ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SKID_EMPTY;
            in_ready_q  <= 1'b0;
            main_meta_q <= '0;
            skid_meta_q <= '0;
            main_imm_q  <= '0;
            skid_imm_q  <= '0;
            main_tag_q  <= '0;
            skid_tag_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID_FULL);

            if (ld_main_in) begin
                main_meta_q <= in_meta;
                main_imm_q  <= dec_imm;
                main_tag_q  <= in_tag;
            end else if (ld_main_skid) begin
                main_meta_q <= skid_meta_q;
                main_imm_q  <= skid_imm_q;
                main_tag_q  <= skid_tag_q;
            end

            if (ld_skid) begin
                skid_meta_q <= in_meta;
                skid_imm_q  <= dec_imm;
                skid_tag_q  <= in_tag;
            end

            if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_inst  = main_meta_q.inst;
    assign out_fmt   = main_meta_q.fmt;
    assign out_zimm  = main_meta_q.zimm;
    assign out_imm   = main_imm_q;
    assign out_tag   = main_tag_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: three configurations (32/sext, 64/sext/2-bit counter, 64/zext) share one stimulus stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_tag = '0;
    logic        out_ready = 1'b1;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_inst, a_out_tag, a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [4:0]  a_out_zimm;
    logic [15:0] a_stall_cnt;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_inst, b_out_tag;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;
    logic [4:0]  b_out_zimm;
    logic [1:0]  b_stall_cnt;

    logic        c_in_ready, c_out_valid;
    logic [31:0] c_out_inst, c_out_tag;
    logic [63:0] c_out_imm;
    logic [2:0]  c_out_fmt;
    logic [4:0]  c_out_zimm;
    logic [15:0] c_stall_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SIGN_EXT(1), .TAG_W(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_inst(a_out_inst), .out_tag(a_out_tag), .out_imm(a_out_imm),
        .out_fmt(a_out_fmt), .out_zimm(a_out_zimm), .stall_cnt(a_stall_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .SIGN_EXT(1), .TAG_W(32), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_inst(b_out_inst), .out_tag(b_out_tag), .out_imm(b_out_imm),
        .out_fmt(b_out_fmt), .out_zimm(b_out_zimm), .stall_cnt(b_stall_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .SIGN_EXT(0), .TAG_W(32), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_inst(c_out_inst), .out_tag(c_out_tag), .out_imm(c_out_imm),
        .out_fmt(c_out_fmt), .out_zimm(c_out_zimm), .stall_cnt(c_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0;
        tick();
        total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0)
            $display("FAIL reset_valids: out_valid=%b in_ready=%b expected 0/0", a_out_valid, a_in_ready);
        else passed++;
        total++; if ({a_out_imm, a_out_inst, a_out_tag, a_out_fmt, a_out_zimm} !== '0 || a_stall_cnt !== 16'd0)
            $display("FAIL reset_fields: imm=%h inst=%h tag=%h fmt=%0d zimm=%0d cnt=%0d expected all 0",
                     a_out_imm, a_out_inst, a_out_tag, a_out_fmt, a_out_zimm, a_stall_cnt);
        else passed++;
        rst = 1'b1;
        tick();
        total++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1)
            $display("FAIL reset_release_ready: a=%b b=%b expected 1", a_in_ready, b_in_ready);
        else passed++;
    endtask

    task automatic test_addi();
        do_reset();
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 32'h100; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (a_out_valid !== 1'b1 || a_out_imm !== 32'hFFFFFFFF || a_out_fmt !== 3'd1 || a_out_tag !== 32'h100)
            $display("FAIL addi32: valid=%b imm=%h fmt=%0d tag=%h expected 1 ffffffff 1 100",
                     a_out_valid, a_out_imm, a_out_fmt, a_out_tag);
        else passed++;
        total++; if (b_out_imm !== 64'hFFFFFFFFFFFFFFFF)
            $display("FAIL addi64_sext: got %h expected ffffffffffffffff", b_out_imm);
        else passed++;
        total++; if (c_out_imm !== 64'h0000000000000FFF)
            $display("FAIL addi64_zext: got %h expected 0000000000000fff", c_out_imm);
        else passed++;
        tick();
        total++; if (a_out_valid !== 1'b0)
            $display("FAIL addi_drain: out_valid=%b expected 0", a_out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v_inst [7] = '{32'hFE112E23, 32'hFF9FF06F, 32'h34029073, 32'hFE000EE3,
                                    32'hF14020F3, 32'h12345097, 32'hFFFFFFB3};
        logic [31:0] v_imm  [7] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000340, 32'hFFFFFFFC,
                                    32'h00000F14, 32'h12345000, 32'h00000000};
        logic [2:0]  v_fmt  [7] = '{3'd2, 3'd5, 3'd6, 3'd3, 3'd6, 3'd4, 3'd0};
        logic [4:0]  v_zimm [7] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_inst = v_inst[i]; in_tag = 32'h1000 + i;
            tick();
            total++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1 || a_out_inst !== v_inst[i] || a_out_tag !== 32'h1000 + i)
                $display("FAIL b2b_flow[%0d]: valid=%b in_ready=%b inst=%h tag=%h expected 1 1 %h %h",
                         i, a_out_valid, a_in_ready, a_out_inst, a_out_tag, v_inst[i], 32'h1000 + i);
            else passed++;
            total++; if (a_out_imm !== v_imm[i] || a_out_fmt !== v_fmt[i] || a_out_zimm !== v_zimm[i])
                $display("FAIL b2b_decode[%0d]: imm=%h fmt=%0d zimm=%0d expected %h %0d %0d",
                         i, a_out_imm, a_out_fmt, a_out_zimm, v_imm[i], v_fmt[i], v_zimm[i]);
            else passed++;
        end
        in_valid = 1'b0;
        tick();
        total++; if (a_out_valid !== 1'b0)
            $display("FAIL b2b_end: out_valid=%b expected 0", a_out_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00100093; in_tag = 32'hA;
        tick();  // A accepted
        total++; if (a_out_valid !== 1'b1 || a_out_inst !== 32'h00100093 || a_in_ready !== 1'b1)
            $display("FAIL bp_first: valid=%b inst=%h in_ready=%b expected 1 00100093 1",
                     a_out_valid, a_out_inst, a_in_ready);
        else passed++;
        in_inst = 32'h00200093; in_tag = 32'hB;
        tick();  // B accepted into skid
        total++; if (a_in_ready !== 1'b0 || a_out_inst !== 32'h00100093 || a_out_imm !== 32'd1 || a_stall_cnt !== 16'd1)
            $display("FAIL bp_full: in_ready=%b inst=%h imm=%h cnt=%0d expected 0 00100093 1 1",
                     a_in_ready, a_out_inst, a_out_imm, a_stall_cnt);
        else passed++;
        in_inst = 32'h00300093; in_tag = 32'hC;
        tick();
        tick();
        total++; if (a_in_ready !== 1'b0 || a_out_tag !== 32'hA || a_stall_cnt !== 16'd3)
            $display("FAIL bp_hold: in_ready=%b tag=%h cnt=%0d expected 0 a 3", a_in_ready, a_out_tag, a_stall_cnt);
        else passed++;
        out_ready = 1'b1;
        tick();  // A leaves, B to main
        total++; if (a_out_valid !== 1'b1 || a_out_tag !== 32'hB || a_out_imm !== 32'd2 || a_in_ready !== 1'b1)
            $display("FAIL bp_drain_b: valid=%b tag=%h imm=%h in_ready=%b expected 1 b 2 1",
                     a_out_valid, a_out_tag, a_out_imm, a_in_ready);
        else passed++;
        tick();  // C accepted, B leaves
        in_valid = 1'b0;
        total++; if (a_out_valid !== 1'b1 || a_out_tag !== 32'hC || a_out_imm !== 32'd3 || a_stall_cnt !== 16'd3)
            $display("FAIL bp_drain_c: valid=%b tag=%h imm=%h cnt=%0d expected 1 c 3 3",
                     a_out_valid, a_out_tag, a_out_imm, a_stall_cnt);
        else passed++;
        tick();
        total++; if (a_out_valid !== 1'b0)
            $display("FAIL bp_empty: out_valid=%b expected 0 (duplicate entry)", a_out_valid);
        else passed++;
    endtask

    task automatic test_xlen64();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h800000B7;
        tick();
        total++; if (b_out_imm !== 64'hFFFFFFFF80000000 || b_out_fmt !== 3'd4)
            $display("FAIL lui64_sext: imm=%h fmt=%0d expected ffffffff80000000 4", b_out_imm, b_out_fmt);
        else passed++;
        total++; if (c_out_imm !== 64'h0000000080000000)
            $display("FAIL lui64_zext: imm=%h expected 0000000080000000", c_out_imm);
        else passed++;
        total++; if (a_out_imm !== 32'h80000000)
            $display("FAIL lui32: imm=%h expected 80000000", a_out_imm);
        else passed++;
        in_inst = 32'hFFF0009B;
        tick();
        total++; if (a_out_fmt !== 3'd0 || a_out_imm !== 32'h0)
            $display("FAIL opimm32_xlen32: fmt=%0d imm=%h expected 0 0", a_out_fmt, a_out_imm);
        else passed++;
        total++; if (b_out_fmt !== 3'd1 || b_out_imm !== 64'hFFFFFFFFFFFFFFFF)
            $display("FAIL opimm32_xlen64: fmt=%0d imm=%h expected 1 ffffffffffffffff", b_out_fmt, b_out_imm);
        else passed++;
        total++; if (c_out_imm !== 64'h0000000000000FFF)
            $display("FAIL opimm32_zext: imm=%h expected 0000000000000fff", c_out_imm);
        else passed++;
        in_inst = 32'hFF9FF06F;
        tick();
        in_valid = 1'b0;
        total++; if (b_out_imm !== 64'hFFFFFFFFFFFFFFF8 || c_out_imm !== 64'h00000000001FFFF8)
            $display("FAIL jal64: sext=%h zext=%h expected fffffffffffffff8 00000000001ffff8", b_out_imm, c_out_imm);
        else passed++;
        tick();
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00100093;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (b_stall_cnt !== exp_cnt[i])
                $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, b_stall_cnt, exp_cnt[i]);
            else passed++;
        end
        total++; if (a_stall_cnt !== 16'd6)
            $display("FAIL wide_cnt: got %0d expected 6", a_stall_cnt);
        else passed++;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_full();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500093; in_tag = 32'hDEAD;
        tick();
        in_inst = 32'h00600093; in_tag = 32'hBEEF;
        tick();
        total++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1)
            $display("FAIL rf_setup: in_ready=%b out_valid=%b expected 0 1", a_in_ready, a_out_valid);
        else passed++;
        in_valid = 1'b0; rst = 1'b0;
        tick();
        total++; if (a_out_valid !== 1'b0 || a_stall_cnt !== 16'd0 || a_in_ready !== 1'b0 || a_out_tag !== 32'h0)
            $display("FAIL rf_reset: valid=%b cnt=%0d in_ready=%b tag=%h expected 0 0 0 0",
                     a_out_valid, a_stall_cnt, a_in_ready, a_out_tag);
        else passed++;
        rst = 1'b1; out_ready = 1'b1;
        tick();
        total++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0)
            $display("FAIL rf_release: in_ready=%b valid=%b expected 1 0", a_in_ready, a_out_valid);
        else passed++;
        tick();
        total++; if (a_out_valid !== 1'b0)
            $display("FAIL rf_ghost: valid=%b tag=%h expected no old entry", a_out_valid, a_out_tag);
        else passed++;
        in_valid = 1'b1; in_inst = 32'h00700093; in_tag = 32'h77;
        tick();
        in_valid = 1'b0;
        total++; if (a_out_valid !== 1'b1 || a_out_tag !== 32'h77 || a_out_imm !== 32'd7)
            $display("FAIL rf_new: valid=%b tag=%h imm=%h expected 1 77 7", a_out_valid, a_out_tag, a_out_imm);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_xlen64();
        test_saturate();
        test_reset_full();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
